// File: rtl/cache_pkg.sv
// Shared types and helpers for the direct-mapped cache controller.
// Holds the FSM state enum, address-field widths and block word helpers.
package cache_pkg;

    typedef enum logic [2:0] {
        IDLE,
        COMPARE,
        WRITEBACK,
        ALLOCATE,
        WRITE_MEM
    } state_t;

    // Widest block the helpers handle; callers widen/narrow with casts.
    localparam int MAX_WORDS = 32;
    localparam int MAX_BLK_W = 32 * MAX_WORDS;

    typedef logic [MAX_BLK_W-1:0] blk_t;

    function automatic int offW(input int wordsPerBlk);
        return $clog2(wordsPerBlk) + 2;
    endfunction

    function automatic int idxW(input int numSets);
        return $clog2(numSets);
    endfunction

    function automatic int tagW(input int addrW,
                                input int numSets,
                                input int wordsPerBlk);
        return addrW - idxW(numSets) - offW(wordsPerBlk);
    endfunction

    function automatic logic [31:0] wordSel(input blk_t blk,
                                            input int w);
        return blk[32*w +: 32];
    endfunction

    function automatic blk_t wordIns(input blk_t blk,
                                     input int w,
                                     input logic [31:0] d);
        blk_t r;
        r = blk;
        r[32*w +: 32] = d;
        return r;
    endfunction

endpackage

// File: rtl/cache_line_array.sv
// Tag/valid/dirty/data storage for a direct-mapped cache.
// Ports: clk, reset; idx selects the line for both the combinational read
// (rdTag/rdData/rdValid/rdDirty) and the synchronous write (wrEn/wrTag/
// wrData/wrDirty). A write always marks the line valid.
module cache_line_array #(
    parameter int NUM_SETS = 2,
    parameter int IDX_W    = 1,
    parameter int TAG_W    = 5,
    parameter int BLK_W    = 128
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [IDX_W-1:0] idx,
    output logic [TAG_W-1:0] rdTag,
    output logic [BLK_W-1:0] rdData,
    output logic             rdValid,
    output logic             rdDirty,
    input  logic             wrEn,
    input  logic [TAG_W-1:0] wrTag,
    input  logic [BLK_W-1:0] wrData,
    input  logic             wrDirty
);

    logic [TAG_W-1:0]    tags  [NUM_SETS];
    logic [BLK_W-1:0]    data  [NUM_SETS];
    logic [NUM_SETS-1:0] valid;
    logic [NUM_SETS-1:0] dirty;

    assign rdTag   = tags[idx];
    assign rdData  = data[idx];
    assign rdValid = valid[idx];
    assign rdDirty = dirty[idx];

    // Tag and data arrays carry no reset; valid gates their use.
    always_ff @(posedge clk) begin
        if (wrEn) begin
            tags[idx] <= wrTag;
            data[idx] <= wrData;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid <= '0;
            dirty <= '0;
        end else if (wrEn) begin
            valid[idx] <= 1'b1;
            dirty[idx] <= wrDirty;
        end
    end

endmodule

// File: rtl/wb_cache_ctrl.sv
// Direct-mapped cache controller, write-back or write-through, block memory port.
// CPU side: cpu_req/we/addr/wdata in, cpu_rdata/ready/hit out.
// Memory side: mem_req/we/addr/wdata out, mem_rdata/mem_ready in.
module wb_cache_ctrl
    import cache_pkg::*;
#(
    parameter int ADDR_W        = 10,
    parameter int NUM_SETS      = 2,
    parameter int WORDS_PER_BLK = 4,
    parameter int WRITE_BACK    = 1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       cpu_req,
    input  logic                       cpu_we,
    input  logic [ADDR_W-1:0]          cpu_addr,
    input  logic [31:0]                cpu_wdata,
    output logic [31:0]                cpu_rdata,
    output logic                       cpu_ready,
    output logic                       cpu_hit,
    output logic                       mem_req,
    output logic                       mem_we,
    output logic [ADDR_W-1:0]          mem_addr,
    output logic [32*WORDS_PER_BLK-1:0] mem_wdata,
    input  logic [32*WORDS_PER_BLK-1:0] mem_rdata,
    input  logic                       mem_ready
);

    localparam int OFF_W = offW(WORDS_PER_BLK);
    localparam int IDX_W = idxW(NUM_SETS);
    localparam int TAG_W = tagW(ADDR_W, NUM_SETS, WORDS_PER_BLK);
    localparam int BLK_W = 32 * WORDS_PER_BLK;

    state_t state, nextState;

    logic [ADDR_W-1:0] addrQ;
    logic              weQ;
    logic [31:0]       wdataQ;
    logic              missQ;
    logic              setMiss;

    logic [TAG_W-1:0] tag;
    logic [IDX_W-1:0] idx;
    int               wordIdx;

    logic [TAG_W-1:0] lineTag;
    logic [BLK_W-1:0] lineData;
    logic             lineValid;
    logic             lineDirty;
    logic             hit;

    logic             wrEn;
    logic [BLK_W-1:0] wrData;
    logic             wrDirty;

    logic [31:0]      curWord;
    blk_t             insFull;
    logic [BLK_W-1:0] updLine;

    assign tag     = addrQ[ADDR_W-1 -: TAG_W];
    assign idx     = addrQ[OFF_W +: IDX_W];
    assign wordIdx = int'(addrQ[OFF_W-1:0]) / 4;
    assign hit     = lineValid && (lineTag == tag);
    assign curWord = wordSel(blk_t'(lineData), wordIdx);
    assign insFull = wordIns(blk_t'(lineData), wordIdx, wdataQ);
    assign updLine = insFull[BLK_W-1:0];

    cache_line_array #(
        .NUM_SETS(NUM_SETS),
        .IDX_W   (IDX_W),
        .TAG_W   (TAG_W),
        .BLK_W   (BLK_W)
    ) lines (
        .clk    (clk),
        .reset  (reset),
        .idx    (idx),
        .rdTag  (lineTag),
        .rdData (lineData),
        .rdValid(lineValid),
        .rdDirty(lineDirty),
        .wrEn   (wrEn),
        .wrTag  (tag),
        .wrData (wrData),
        .wrDirty(wrDirty)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            addrQ  <= '0;
            weQ    <= 1'b0;
            wdataQ <= '0;
            missQ  <= 1'b0;
        end else begin
            state <= nextState;
            if (state == IDLE) begin
                missQ <= 1'b0;
            end else if (setMiss) begin
                missQ <= 1'b1;
            end
            if (state == IDLE && cpu_req) begin
                addrQ  <= cpu_addr;
                weQ    <= cpu_we;
                wdataQ <= cpu_wdata;
            end
        end
    end

    // Outputs are forced low while reset is held so an aborted
    // transaction cannot leak a ready pulse or memory request.
    always_comb begin
        nextState = state;
        cpu_rdata = '0;
        cpu_ready = 1'b0;
        cpu_hit   = 1'b0;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        wrEn      = 1'b0;
        wrData    = updLine;
        wrDirty   = 1'b0;
        setMiss   = 1'b0;
        if (!reset) begin
            unique case (state)
                IDLE: begin
                    if (cpu_req) nextState = COMPARE;
                end
                COMPARE: begin
                    unique case (1'b1)
                        hit && !weQ: begin
                            cpu_ready = 1'b1;
                            cpu_rdata = curWord;
                            cpu_hit   = !missQ;
                            nextState = IDLE;
                        end
                        hit && weQ && (WRITE_BACK != 0): begin
                            wrEn      = 1'b1;
                            wrDirty   = 1'b1;
                            cpu_ready = 1'b1;
                            cpu_hit   = !missQ;
                            nextState = IDLE;
                        end
                        hit && weQ && (WRITE_BACK == 0): begin
                            wrEn      = 1'b1;
                            nextState = WRITE_MEM;
                        end
                        default: begin
                            setMiss = 1'b1;
                            if ((WRITE_BACK != 0) && lineValid && lineDirty)
                                nextState = WRITEBACK;
                            else
                                nextState = ALLOCATE;
                        end
                    endcase
                end
                WRITEBACK: begin
                    mem_req   = 1'b1;
                    mem_we    = 1'b1;
                    mem_addr  = {lineTag, idx, {OFF_W{1'b0}}};
                    mem_wdata = lineData;
                    if (mem_ready) nextState = ALLOCATE;
                end
                ALLOCATE: begin
                    mem_req  = 1'b1;
                    mem_addr = {tag, idx, {OFF_W{1'b0}}};
                    if (mem_ready) begin
                        wrEn      = 1'b1;
                        wrData    = mem_rdata;
                        nextState = COMPARE;
                    end
                end
                WRITE_MEM: begin
                    mem_req   = 1'b1;
                    mem_we    = 1'b1;
                    mem_addr  = {tag, idx, {OFF_W{1'b0}}};
                    mem_wdata = lineData;
                    if (mem_ready) begin
                        cpu_ready = 1'b1;
                        cpu_hit   = !missQ;
                        nextState = IDLE;
                    end
                end
                default: nextState = IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_wb_cache_ctrl.sv
// Bench for wb_cache_ctrl: lane 0 write-back, lane 1 write-through.
// Transaction-level cache/memory model plus a per-cycle compare process.
module tb_wb_cache_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst       [2];
    logic         cpuReq    [2];
    logic         cpuWe     [2];
    logic [9:0]   cpuAddr   [2];
    logic [31:0]  cpuWdata  [2];
    logic [31:0]  cpuRdata  [2];
    logic         cpuReady  [2];
    logic         cpuHit    [2];
    logic         memReq    [2];
    logic         memWe     [2];
    logic [9:0]   memAddr   [2];
    logic [127:0] memWdata  [2];
    logic [127:0] memRdata  [2];
    logic         memReady  [2];

    wb_cache_ctrl #(.ADDR_W(10), .NUM_SETS(2), .WORDS_PER_BLK(4), .WRITE_BACK(1)) dutWb (
        .clk(clk), .reset(rst[0]), .cpu_req(cpuReq[0]), .cpu_we(cpuWe[0]),
        .cpu_addr(cpuAddr[0]), .cpu_wdata(cpuWdata[0]), .cpu_rdata(cpuRdata[0]),
        .cpu_ready(cpuReady[0]), .cpu_hit(cpuHit[0]), .mem_req(memReq[0]),
        .mem_we(memWe[0]), .mem_addr(memAddr[0]), .mem_wdata(memWdata[0]),
        .mem_rdata(memRdata[0]), .mem_ready(memReady[0]));

    wb_cache_ctrl #(.ADDR_W(10), .NUM_SETS(2), .WORDS_PER_BLK(4), .WRITE_BACK(0)) dutWt (
        .clk(clk), .reset(rst[1]), .cpu_req(cpuReq[1]), .cpu_we(cpuWe[1]),
        .cpu_addr(cpuAddr[1]), .cpu_wdata(cpuWdata[1]), .cpu_rdata(cpuRdata[1]),
        .cpu_ready(cpuReady[1]), .cpu_hit(cpuHit[1]), .mem_req(memReq[1]),
        .mem_we(memWe[1]), .mem_addr(memAddr[1]), .mem_wdata(memWdata[1]),
        .mem_rdata(memRdata[1]), .mem_ready(memReady[1]));

    typedef struct {
        logic         we;
        logic [9:0]   addr;
        logic [127:0] data;
    } op_t;

    typedef struct {
        bit          isRead;
        logic [31:0] rdata;
        bit          hit;
    } resp_t;

    op_t   opQ[$];
    resp_t respQ[$];

    int checks = 0;
    int errors = 0;

    // Model: per-lane cache contents and expected memory image.
    bit           mValid   [2][2];
    bit           mDirty   [2][2];
    int           mTag     [2][2];
    logic [127:0] mData    [2][2];
    logic [31:0]  modelMem [2][256];
    logic [31:0]  envMem   [2][256];

    int readyCount [2];
    bit prevReq    [2];
    bit prevRdy    [2];
    logic         prevWe   [2];
    logic [9:0]   prevAddr [2];
    logic [127:0] prevData [2];

    int           lat;
    int           nHs;
    logic         op0We;
    logic [9:0]   op0Addr;
    logic [127:0] op0Data;
    logic [31:0]  gotRdata;
    logic         gotHit;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [127:0] blkOf(input int ln, input int base, input bit fromModel);
        logic [127:0] b;
        for (int k = 0; k < 4; k++)
            b[32*k +: 32] = fromModel ? modelMem[ln][base+k] : envMem[ln][base+k];
        return b;
    endfunction

    task automatic modelOp(input int ln, input bit we, input logic [9:0] a, input logic [31:0] d);
        int idx, tg, w, base, vb;
        bit wb, h;
        idx  = (int'(a) >> 4) % 2;
        tg   = int'(a) >> 5;
        w    = (int'(a) >> 2) % 4;
        base = (int'(a) >> 4) * 4;
        wb   = (ln == 0);
        h    = mValid[ln][idx] && (mTag[ln][idx] == tg);
        if (!h) begin
            if (wb && mValid[ln][idx] && mDirty[ln][idx]) begin
                vb = (mTag[ln][idx] * 2 + idx) * 4;
                opQ.push_back('{1'b1, 10'(vb * 4), mData[ln][idx]});
                for (int k = 0; k < 4; k++)
                    modelMem[ln][vb+k] = mData[ln][idx][32*k +: 32];
            end
            opQ.push_back('{1'b0, 10'(base * 4), 128'h0});
            mData[ln][idx]  = blkOf(ln, base, 1'b1);
            mValid[ln][idx] = 1'b1;
            mDirty[ln][idx] = 1'b0;
            mTag[ln][idx]   = tg;
        end
        if (!we) begin
            respQ.push_back('{1'b1, mData[ln][idx][32*w +: 32], h});
        end else begin
            mData[ln][idx][32*w +: 32] = d;
            if (wb) begin
                mDirty[ln][idx] = 1'b1;
            end else begin
                opQ.push_back('{1'b1, 10'(base * 4), mData[ln][idx]});
                modelMem[ln][base+w] = d;
            end
            respQ.push_back('{1'b0, 32'h0, h});
        end
    endtask

    // Per-cycle comparison of both lanes against the model's expectations.
    always @(negedge clk) begin
        for (int ln = 0; ln < 2; ln++) begin
            if (rst[ln]) begin
                prevReq[ln] = 1'b0;
                prevRdy[ln] = 1'b0;
            end else begin
                if (prevReq[ln] && !prevRdy[ln]) begin
                    chk("mem hold req", memReq[ln], 1'b1);
                    chk("mem hold bus", {memWe[ln], memAddr[ln], memWdata[ln]},
                        {prevWe[ln], prevAddr[ln], prevData[ln]});
                end
                if (memReq[ln] && memReady[ln]) begin
                    if (opQ.size() == 0) begin
                        chk("unexpected mem op", 1'b1, 1'b0);
                    end else begin
                        op_t e;
                        e = opQ.pop_front();
                        chk("mem_we", memWe[ln], e.we);
                        chk("mem_addr", memAddr[ln], e.addr);
                        if (e.we) chk("mem_wdata", memWdata[ln], e.data);
                    end
                end
                if (cpuReady[ln]) begin
                    readyCount[ln]++;
                    if (respQ.size() == 0) begin
                        chk("unexpected cpu_ready", 1'b1, 1'b0);
                    end else begin
                        resp_t r;
                        r = respQ.pop_front();
                        chk("cpu_hit", cpuHit[ln], r.hit);
                        if (r.isRead) chk("cpu_rdata", cpuRdata[ln], r.rdata);
                    end
                end
                prevReq[ln]  = memReq[ln];
                prevRdy[ln]  = memReady[ln];
                prevWe[ln]   = memWe[ln];
                prevAddr[ln] = memAddr[ln];
                prevData[ln] = memWdata[ln];
            end
        end
    end

    // Entered and left just after a rising edge.
    task automatic runOp(input int ln, input bit we, input logic [9:0] a,
                         input logic [31:0] d, input int dly, input bit hold);
        bit done;
        int cnt, b;
        modelOp(ln, we, a, d);
        cpuReq[ln] = 1'b1; cpuWe[ln] = we; cpuAddr[ln] = a; cpuWdata[ln] = d;
        lat = 0; nHs = 0; done = 1'b0; cnt = 0;
        for (int c = 0; c < 200 && !done; c++) begin
            @(negedge clk);
            if (lat > 0 && cpuReady[ln]) begin
                done = 1'b1;
                gotRdata = cpuRdata[ln];
                gotHit = cpuHit[ln];
            end
            @(posedge clk); #1;
            if (!hold || done) cpuReq[ln] = 1'b0;
            if (memReady[ln]) begin
                memReady[ln] = 1'b0;
                cnt = 0;
            end
            if (!done) begin
                lat++;
                if (memReq[ln]) begin
                    if (cnt >= dly) begin
                        memReady[ln] = 1'b1;
                        if (nHs == 0) begin
                            op0We = memWe[ln]; op0Addr = memAddr[ln]; op0Data = memWdata[ln];
                        end
                        nHs++;
                        b = int'(memAddr[ln]) / 4;
                        if (memWe[ln]) begin
                            for (int k = 0; k < 4; k++)
                                envMem[ln][b+k] = memWdata[ln][32*k +: 32];
                        end else begin
                            memRdata[ln] = blkOf(ln, b, 1'b0);
                        end
                    end else begin
                        cnt++;
                    end
                end
            end
        end
        chk("op timeout", done, 1'b1);
        chk("ops left", opQ.size(), 0);
    endtask

    task automatic doReset(input int ln);
        rst[ln] = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst[ln] = 1'b0;
        for (int s = 0; s < 2; s++) begin
            mValid[ln][s] = 1'b0;
            mDirty[ln][s] = 1'b0;
        end
        @(negedge clk);
        chk("reset flags", {cpuReady[ln], cpuHit[ln], memReq[ln], memWe[ln]}, 4'h0);
        chk("reset data", {cpuRdata[ln], memAddr[ln]}, 42'h0);
        chk("reset wdata", memWdata[ln], 128'h0);
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int rc, k;
        bit seen;
        for (int ln = 0; ln < 2; ln++) begin
            rst[ln] = 1'b1; cpuReq[ln] = 0; cpuWe[ln] = 0; cpuAddr[ln] = 0;
            cpuWdata[ln] = 0; memRdata[ln] = 0; memReady[ln] = 0;
            readyCount[ln] = 0;
            for (int w = 0; w < 256; w++) begin
                modelMem[ln][w] = 32'h5000_0000 + 32'(w);
                envMem[ln][w] = 32'h5000_0000 + 32'(w);
            end
            modelMem[ln][0] = 32'hAAAA0000; envMem[ln][0] = 32'hAAAA0000;
            modelMem[ln][1] = 32'hBBBB1111; envMem[ln][1] = 32'hBBBB1111;
            modelMem[ln][2] = 32'hCCCC2222; envMem[ln][2] = 32'hCCCC2222;
            modelMem[ln][3] = 32'hDDDD3333; envMem[ln][3] = 32'hDDDD3333;
        end
        @(posedge clk); #1;

        // Write-back lane.
        doReset(0);
        runOp(0, 0, 10'h000, 0, 0, 0);
        chk("t1 fill op", {op0We, op0Addr}, {1'b0, 10'h000});
        chk("t1 rdata A", gotRdata, 32'hAAAA0000);
        chk("t1 miss", gotHit, 1'b0);
        runOp(0, 0, 10'h004, 0, 0, 0);
        chk("t1 hit rdata B", {gotHit, gotRdata}, {1'b1, 32'hBBBB1111});
        chk("t1 hit latency", lat, 1);
        runOp(0, 1, 10'h008, 32'hDEADBEEF, 0, 0);
        chk("t2 wr hit no mem", nHs, 0);
        chk("t2 wr hit latency", lat, 1);
        runOp(0, 0, 10'h020, 0, 0, 0);
        chk("t2 evict op", {nHs[1:0], op0We, op0Addr}, {2'd2, 1'b1, 10'h000});
        chk("t2 evict word2", op0Data[95:64], 32'hDEADBEEF);
        chk("t2 evict miss", gotHit, 1'b0);
        runOp(0, 0, 10'h010, 0, 5, 0);
        chk("t4 slow latency", lat, 8);
        chk("t4 rdata", gotRdata, 32'h50000004);
        memReady[0] = 1'b1;
        repeat (3) @(posedge clk);
        #1 memReady[0] = 1'b0;
        @(negedge clk);
        chk("t4 idle ready ignored", memReq[0], 1'b0);
        @(posedge clk); #1;
        runOp(0, 0, 10'h014, 0, 0, 0);
        chk("t4 hit after idle ready", {gotHit, lat[3:0]}, {1'b1, 4'd1});
        runOp(0, 1, 10'h028, 32'h00000011, 0, 0);

        cpuReq[0] = 1'b1; cpuWe[0] = 1'b0; cpuAddr[0] = 10'h008;
        @(posedge clk); #1 cpuReq[0] = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 20 && !seen; c++) begin
            @(negedge clk);
            if (memReq[0] && memWe[0]) seen = 1'b1;
        end
        chk("t5 writeback seen", seen, 1'b1);
        chk("t5 victim addr", memAddr[0], 10'h020);
        rc = readyCount[0];
        @(posedge clk); #1 rst[0] = 1'b1;
        @(posedge clk); #1 rst[0] = 1'b0;
        for (int s = 0; s < 2; s++) begin
            mValid[0][s] = 1'b0;
            mDirty[0][s] = 1'b0;
        end
        @(negedge clk);
        chk("t5 post-reset mem_req", memReq[0], 1'b0);
        chk("t5 post-reset ready", readyCount[0] - rc, 0);
        @(posedge clk); #1;
        runOp(0, 0, 10'h008, 0, 0, 0);
        chk("t5 refill only", {nHs[1:0], op0We, op0Addr}, {2'd1, 1'b0, 10'h000});
        chk("t5 refill data", {gotHit, gotRdata}, {1'b0, 32'hDEADBEEF});

        runOp(0, 0, 10'h010, 0, 0, 0);
        runOp(0, 0, 10'h000, 0, 0, 0);
        chk("t6 set0 hit", {gotHit, gotRdata}, {1'b1, 32'hAAAA0000});
        runOp(0, 0, 10'h010, 0, 0, 0);
        chk("t6 set1 hit", {gotHit, gotRdata}, {1'b1, 32'h50000004});
        rc = readyCount[0];
        runOp(0, 0, 10'h030, 0, 2, 1);
        repeat (3) @(negedge clk);
        chk("t6 held req one ready", readyCount[0] - rc, 1);
        @(posedge clk); #1;

        // Write-through lane.
        doReset(1);
        runOp(1, 0, 10'h000, 0, 0, 0);
        runOp(1, 1, 10'h004, 32'h12345678, 3, 0);
        chk("t3 wt op", {nHs[1:0], op0We, op0Addr}, {2'd1, 1'b1, 10'h000});
        chk("t3 wt word1", op0Data[63:32], 32'h12345678);
        chk("t3 wt latency", lat, 5);
        chk("t3 wt hit", gotHit, 1'b1);
        runOp(1, 1, 10'h018, 32'hCAFEF00D, 0, 0);
        chk("t3 wt write miss", {nHs[1:0], gotHit}, {2'd2, 1'b0});
        runOp(1, 0, 10'h018, 0, 0, 0);
        chk("t3 wt reread", {gotHit, gotRdata}, {1'b1, 32'hCAFEF00D});
        runOp(1, 0, 10'h020, 0, 0, 0);
        chk("t3 wt no writeback", {nHs[1:0], op0We}, {2'd1, 1'b0});
        runOp(1, 0, 10'h004, 0, 0, 0);
        chk("t3 wt memory updated", {gotHit, gotRdata}, {1'b0, 32'h12345678});

        k = respQ.size();
        chk("responses left", k, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
